// File: rtl/sdrc_app_req_arb.sv
// sdrc_app_req_arb
// Two-port application request arbiter in front of the SDRAM request
// generator. A request from port0 or port1 is captured into a holding
// register and presented on req/req_* until the request generator accepts
// it with req_ack. Each accepted request's {port, direction} is pushed into
// a small order FIFO. The data-path steering logic reads the head of that
// FIFO and pops it with xfr_done once the transfer has finished.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   pX_req..pX_wr_n   port X request (level, held until pX_ack) and fields
//   pX_ack            1-cycle pulse in the cycle port X's request is captured
//   req, req_*        held request towards the request generator
//   req_port          port that owns the held request
//   req_ack           request generator accepted the held request
//   ord_vld           order FIFO not empty
//   ord_port/ord_wr_n head entry of the order FIFO (0 when empty)
//   xfr_done          pop the order FIFO head
//   arb_idle          nothing held, nothing requested, order FIFO empty
//
// Optional feature: define SDRC_ARB_PRIO_EN to add p0_pri/p1_pri. When both
// ports request with different priorities, the high-priority port wins;
// otherwise arbitration is round-robin.

module sdrc_app_req_arb #(
  parameter int APP_AW    = 30,
  parameter int APP_RW    = 9,
  parameter int ID_W      = 4,
  parameter int ORD_DEPTH = 4,
  parameter int ORD_AW    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic [ID_W-1:0]   p0_req_id,
  input  logic [APP_AW:0]   p0_addr,
  input  logic [APP_AW-2:0] p0_addr_mask,
  input  logic [APP_RW-1:0] p0_len,
  input  logic              p0_wrap,
  input  logic              p0_wr_n,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic [ID_W-1:0]   p1_req_id,
  input  logic [APP_AW:0]   p1_addr,
  input  logic [APP_AW-2:0] p1_addr_mask,
  input  logic [APP_RW-1:0] p1_len,
  input  logic              p1_wrap,
  input  logic              p1_wr_n,
  output logic              p1_ack,
`ifdef SDRC_ARB_PRIO_EN
  input  logic              p0_pri,
  input  logic              p1_pri,
`endif
  output logic              req,
  output logic [ID_W-1:0]   req_id,
  output logic [APP_AW:0]   req_addr,
  output logic [APP_AW-2:0] req_addr_mask,
  output logic [APP_RW-1:0] req_len,
  output logic              req_wrap,
  output logic              req_wr_n,
  output logic              req_port,
  input  logic              req_ack,
  output logic              ord_vld,
  output logic              ord_port,
  output logic              ord_wr_n,
  input  logic              xfr_done,
  output logic              arb_idle
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [ORD_AW:0]   ORD_FULL = ORD_DEPTH[ORD_AW:0];
  localparam logic [ORD_AW:0]   CNT_ONE  = {{ORD_AW{1'b0}}, 1'b1};
  localparam logic [ORD_AW-1:0] PTR_ONE  = {{(ORD_AW-1){1'b0}}, 1'b1};

  logic [0:0]        state;
  logic              last_grant;
  logic [ORD_AW-1:0] wr_ptr;
  logic [ORD_AW-1:0] rd_ptr;
  logic [ORD_AW:0]   ord_cnt;
  logic [1:0]        ord_mem [ORD_DEPTH];

  logic fifo_room;
  logic capture;
  logic tie_p1;
  logic sel_p1;
  logic push;
  logic pop;

  always_comb begin
    fifo_room = (ord_cnt < ORD_FULL);
    // Gated by reset_n so the combinational acks stay low during reset.
    capture   = reset_n & (state == ST_IDLE) & (p0_req | p1_req) & fifo_room;
    // On a tie, grant the port that did not win last time.
    tie_p1    = ~last_grant;
`ifdef SDRC_ARB_PRIO_EN
    if (p0_pri != p1_pri) tie_p1 = p1_pri;
`endif
    sel_p1    = p1_req & (~p0_req | tie_p1);
    push      = (state == ST_HOLD) & req_ack;
    pop       = xfr_done & ord_vld;
  end

  assign p0_ack   = capture & ~sel_p1;
  assign p1_ack   = capture & sel_p1;
  assign req      = (state == ST_HOLD);
  assign ord_vld  = (ord_cnt != '0);
  assign ord_port = ord_vld & ord_mem[rd_ptr][1];
  assign ord_wr_n = ord_vld & ord_mem[rd_ptr][0];
  assign arb_idle = (state == ST_IDLE) & ~p0_req & ~p1_req & ~ord_vld;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      last_grant    <= 1'b1;
      req_id        <= '0;
      req_addr      <= '0;
      req_addr_mask <= '0;
      req_len       <= '0;
      req_wrap      <= 1'b0;
      req_wr_n      <= 1'b0;
      req_port      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      ord_cnt       <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (capture) begin
          state         <= ST_HOLD;
          req_port      <= sel_p1;
          last_grant    <= sel_p1;
          req_id        <= sel_p1 ? p1_req_id    : p0_req_id;
          req_addr      <= sel_p1 ? p1_addr      : p0_addr;
          req_addr_mask <= sel_p1 ? p1_addr_mask : p0_addr_mask;
          req_len       <= sel_p1 ? p1_len       : p0_len;
          req_wrap      <= sel_p1 ? p1_wrap      : p0_wrap;
          req_wr_n      <= sel_p1 ? p1_wr_n      : p0_wr_n;
        end
      end else if (req_ack) begin
        state <= ST_IDLE;
      end

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      // Capture is blocked while full, so a push never finds the FIFO full.
      if (push && !pop)      ord_cnt <= ord_cnt + CNT_ONE;
      else if (pop && !push) ord_cnt <= ord_cnt - CNT_ONE;
    end
  end

  // Storage needs no reset: the head is masked by ord_vld.
  always_ff @(posedge clk) begin
    if (push) ord_mem[wr_ptr] <= {req_port, req_wr_n};
  end

endmodule

// File: doc/sdrc_app_req_arb.md
Name: sdrc_app_req_arb

Overview:
- Two-port application request arbiter, upstream of the SDRAM request generator.
- Selects one of two application request ports, holds the winning request stable on the req/req_ack interface until accepted, and records the grant order in a small order FIFO.
- The data-path steering logic reads the order FIFO to route each transfer's data to or from the correct port.

Parameters:
APP_AW, 30, application address width (address bus is APP_AW+1 bits, mask is APP_AW-1 bits)
APP_RW, 9, request length width
ID_W, 4, request ID width
ORD_DEPTH, 4, order FIFO depth (power of two, >=2)
ORD_AW, 2, log2(ORD_DEPTH)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
p0_req  in  1  port0 request valid (level, held until p0_ack)
p0_req_id  in  ID_W  port0 request ID
p0_addr  in  APP_AW+1  port0 start address
p0_addr_mask  in  APP_AW-1  port0 address wrap mask
p0_len  in  APP_RW  port0 length (words)
p0_wrap  in  1  port0 wrap mode
p0_wr_n  in  1  port0 0=write 1=read
p0_ack  out  1  port0 request captured (1-cycle pulse)
p1_*  (same seven inputs and p1_ack as port0)
req  out  1  request to request generator
req_id  out  ID_W  held request ID
req_addr  out  APP_AW+1  held address
req_addr_mask  out  APP_AW-1  held mask
req_len  out  APP_RW  held length
req_wrap  out  1  held wrap
req_wr_n  out  1  held direction
req_port  out  1  port that owns the held request
req_ack  in  1  request generator accepted request
ord_vld  out  1  order FIFO not empty
ord_port  out  1  port of the oldest accepted, uncompleted request
ord_wr_n  out  1  direction of that request
xfr_done  in  1  data transfer of head request complete (pop)
arb_idle  out  1  no held request, no pending port request, order FIFO empty

Behaviour:
- States: IDLE, HOLD.
- IDLE, capture condition: any pX_req=1 and ord_cnt<ORD_DEPTH.
  - Winner: the requesting port if only one requests; if both request, the port not in last_grant.
  - On capture: register the winner's fields into the req_* outputs, set req_port, pulse pX_ack for that port for exactly that cycle, update last_grant, move to HOLD.
  - req rises the following cycle, i.e. one cycle after pX_req is sampled.
- IDLE, FIFO full (ord_cnt==ORD_DEPTH): no capture, no ack, stay in IDLE.
- HOLD:
  - req=1; all req_* outputs stay stable until req_ack.
  - On req_ack: push {req_port, req_wr_n} into the order FIFO, drop req the next cycle, return to IDLE.
  - req_ack in IDLE is ignored.
  - One bubble cycle minimum between accepted requests.
- Order FIFO:
  - Circular buffer with wr_ptr/rd_ptr of ORD_AW bits that wrap naturally; ord_cnt is ORD_AW+1 bits.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop (xfr_done) while empty: ignored, no pointer change.
  - A push cannot overflow, because capture requires ord_cnt<ORD_DEPTH and pops only decrease the count.
  - ord_port and ord_wr_n present the head entry combinationally; both are 0 when empty.
- arb_idle = (state==IDLE) & ~p0_req & ~p1_req & ~ord_vld.
- Reset (synchronous, overrides all):
  - state=IDLE, req=0, p0_ack=p1_ack=0, all req_* fields=0, req_port=0.
  - last_grant=1, so port0 wins the first tie.
  - FIFO pointers and count=0, ord_vld=0.
  - Reset mid-HOLD drops the request, and any entries in the order FIFO are discarded.

Optional Feature:
- Macro: SDRC_ARB_PRIO_EN.
- Defined:
  - Extra inputs p0_pri and p1_pri (1 bit each), sampled with the request.
  - When both ports request and their priorities differ, the port with pri=1 wins regardless of last_grant; last_grant still updates.
  - Equal priorities fall back to round-robin.
- Undefined: the ports do not exist; pure round-robin.

Test Plan:
- After reset, p0_req=1 only (id=3, addr=0x100, len=8, wr_n=0) -> p0_ack pulse in cycle 1, req=1 in cycle 2 with id=3/addr=0x100/len=8; req_ack in cycle 4 -> req=0 in cycle 5, ord_vld=1, ord_port=0, ord_wr_n=0.
- p0_req and p1_req held continuously, req_ack one cycle after each req rise -> grants alternate 0,1,0,1 (port0 first); xfr_done pulsed after each accept so the FIFO never fills.
- ORD_DEPTH=4, four requests accepted with no xfr_done -> ord_cnt=4, a fifth pending p1_req gets no ack; one xfr_done -> capture and p1_ack on the next cycle.
- xfr_done and req_ack in the same cycle with ord_cnt=2 -> ord_cnt stays 2 and head advances to the next port; xfr_done when empty -> no change, ord_vld stays 0.
- reset_n=0 for one cycle while in HOLD with 2 FIFO entries -> next cycle req=0, ord_vld=0, arb_idle=1 once port requests are low.
- With SDRC_ARB_PRIO_EN, p0_pri=0, p1_pri=1, both requesting after reset -> port1 wins despite the round-robin tie rule; with equal pri -> port0 wins.
